// File: rtl/reqrsp_demux_ordered.sv
// Splits one reqrsp slave port into NrPorts master ports by a per-request select.
// Responses are returned strictly in request order through a routing FIFO.
package reqrsp_demux_ordered_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } q_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } p_t;

    typedef struct packed {
        logic q_valid;
        q_t   q;
        logic p_ready;
    } req_t;

    typedef struct packed {
        logic q_ready;
        logic p_valid;
        p_t   p;
    } rsp_t;
endpackage

module reqrsp_demux_ordered #(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = 0,
    parameter int unsigned DataWidth = 0,
    parameter type         req_t     = reqrsp_demux_ordered_pkg::req_t,
    parameter type         rsp_t     = reqrsp_demux_ordered_pkg::rsp_t,
    parameter int unsigned RespDepth = 8,
    parameter int unsigned SelWidth  = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [SelWidth-1:0]        slv_select_i,
    input  req_t                       slv_req_i,
    output rsp_t                       slv_rsp_o,
    output req_t [NrPorts-1:0]         mst_req_o,
    input  rsp_t [NrPorts-1:0]         mst_rsp_i
);
    localparam int unsigned CntWidth = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [SelWidth-1:0] sel_idx, head_idx;
    logic                sel_ok, full, empty, push, pop;
    logic                sel_q_ready, q_ready, p_valid;
    rsp_t                head_rsp;

    assign full  = (cnt_q == CntWidth'(RespDepth));
    assign empty = (cnt_q == '0);

    // A full FIFO blocks acceptance even when a pop is pending this cycle.
    assign q_ready = sel_q_ready & ~full & sel_ok & ~rst_i;
    assign p_valid = head_rsp.p_valid & ~empty & ~rst_i;
    assign push    = slv_req_i.q_valid & q_ready;
    assign pop     = p_valid & slv_req_i.p_ready;

    always_comb begin
        sel_q_ready = 1'b0;
        head_rsp    = '0;
        for (int i = 0; i < NrPorts; i++) begin
            if (sel_idx == SelWidth'(i)) sel_q_ready = mst_rsp_i[i].q_ready;
            if (head_idx == SelWidth'(i)) head_rsp = mst_rsp_i[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NrPorts; i++) begin
            mst_req_o[i]         = '0;
            mst_req_o[i].q       = slv_req_i.q;
            mst_req_o[i].q_valid = slv_req_i.q_valid & ~full & sel_ok & ~rst_i
                                   & (sel_idx == SelWidth'(i));
            mst_req_o[i].p_ready = slv_req_i.p_ready & ~empty & ~rst_i
                                   & (head_idx == SelWidth'(i));
        end
    end

    always_comb begin
        slv_rsp_o         = '0;
        slv_rsp_o.q_ready = q_ready;
        slv_rsp_o.p_valid = p_valid;
        slv_rsp_o.p       = head_rsp.p;
    end

    always_comb cnt_d = cnt_q + CntWidth'(push) - CntWidth'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    if (NrPorts > 1) begin : g_route
        logic [SelWidth-1:0] fifo_q [RespDepth];
        logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

        assign sel_ok   = (32'(slv_select_i) < NrPorts);
        assign sel_idx  = slv_select_i;
        assign head_idx = fifo_q[rptr_q];

        // Explicit wrap so non-power-of-two depths stay in range.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (push) wptr_d = (wptr_q == PtrWidth'(RespDepth - 1)) ? '0 : wptr_q + PtrWidth'(1);
            if (pop)  rptr_d = (rptr_q == PtrWidth'(RespDepth - 1)) ? '0 : rptr_q + PtrWidth'(1);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) fifo_q[wptr_q] <= slv_select_i;
        end
    end else begin : g_single
        // Single target: only the outstanding count matters.
        logic unused_sel;
        assign unused_sel = ^slv_select_i;
        assign sel_ok     = 1'b1;
        assign sel_idx    = '0;
        assign head_idx   = '0;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(slv_req_i.q_valid && !sel_ok))
                else $error("reqrsp_demux_ordered: select %0d out of range", slv_select_i);
            assert ($bits(slv_req_i.q) >= AddrWidth + DataWidth + DataWidth / 8)
                else $error("reqrsp_demux_ordered: request payload narrower than Addr/DataWidth");
        end
    end
`endif
endmodule
